// File: rtl/sdram_burst_tester_if.sv
// Avalon-MM burst bus between the SDRAM burst tester (master) and the memory (slave).
interface sdram_burst_tester_if #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 29,
  parameter int BURST_W = 8
);
  logic [ADDR_W-1:0]   avm_address;
  logic [BURST_W-1:0]  avm_burstcount;
  logic                avm_read;
  logic                avm_write;
  logic [DATA_W-1:0]   avm_writedata;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic                avm_waitrequest;
  logic [DATA_W-1:0]   avm_readdata;
  logic                avm_readdatavalid;

  modport master (
    output avm_address, avm_burstcount, avm_read, avm_write, avm_writedata, avm_byteenable,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_burstcount, avm_read, avm_write, avm_writedata, avm_byteenable,
    output avm_waitrequest, avm_readdata, avm_readdatavalid
  );
endinterface

// File: rtl/sdram_burst_tester.sv
// SDRAM burst tester: writes an address-derived pattern in Avalon bursts, reads it back
// and counts mismatching beats.
module sdram_burst_tester #(
  parameter int          DATA_W  = 64,
  parameter int          ADDR_W  = 29,
  parameter int          BURST_W = 8,
  parameter int          CNT_W   = 16,
  parameter logic [31:0] SEED    = 32'hA5A5_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [CNT_W-1:0]    num_bursts,
  input  logic [BURST_W-1:0]  burst_len,
  sdram_burst_tester_if.master avm,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic [7:0]          leds
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_CMD  = 3'd1,
    WR_DATA = 3'd2,
    RD_CMD  = 3'd3,
    RD_DATA = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam logic [BURST_W-1:0] ONE_B   = {{(BURST_W-1){1'b0}}, 1'b1};
  localparam logic [BURST_W-1:0] MAX_LEN = {1'b1, {(BURST_W-1){1'b0}}};
  localparam logic [ADDR_W-1:0]  ONE_A   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   ALL1_C  = {CNT_W{1'b1}};

  // Only the low 32 address bits feed the pattern; wider addresses alias.
  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
    logic [31:0] w;
    w = 32'(a) + SEED;
    return {(DATA_W/32){w}};
  endfunction

  state_t              state_r;
  logic [1:0]          mode_r;
  logic [ADDR_W-1:0]   base_r;
  logic [CNT_W-1:0]    nb_r;
  logic [BURST_W-1:0]  len_r;
  logic [CNT_W-1:0]    burst_idx_r;
  logic [BURST_W-1:0]  beat_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [ADDR_W-1:0]   address_r;
  logic [BURST_W-1:0]  burstcount_r;
  logic                read_r;
  logic                write_r;
  logic [DATA_W-1:0]   wdata_r;
  logic                busy_r;
  logic                done_r;
  logic [CNT_W-1:0]    err_r;
  logic [ADDR_W-1:0]   first_err_r;

  logic [BURST_W-1:0]  len_eff_s;
  logic [ADDR_W-1:0]   beat_addr_s;
  logic [ADDR_W-1:0]   next_addr_s;
  logic                last_beat_s;
  logic                last_burst_s;
  logic                rd_mismatch_s;

  // Effective burst length: zero means one beat, oversize clamps to the maximum.
  always_comb begin
    if (burst_len == {BURST_W{1'b0}}) begin
      len_eff_s = ONE_B;
    end else if (burst_len > MAX_LEN) begin
      len_eff_s = MAX_LEN;
    end else begin
      len_eff_s = burst_len;
    end
  end

  assign beat_addr_s   = addr_r + ADDR_W'(beat_r);
  assign next_addr_s   = addr_r + ADDR_W'(len_r);
  assign last_beat_s   = (beat_r == (len_r - ONE_B));
  assign last_burst_s  = (burst_idx_r == (nb_r - ONE_C));
  assign rd_mismatch_s = (avm.avm_readdata != pattern(beat_addr_s));

  // Test sequencer: owns every bus output and status register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      mode_r       <= 2'd0;
      base_r       <= '0;
      nb_r         <= '0;
      len_r        <= '0;
      burst_idx_r  <= '0;
      beat_r       <= '0;
      addr_r       <= '0;
      address_r    <= '0;
      burstcount_r <= '0;
      read_r       <= 1'b0;
      write_r      <= 1'b0;
      wdata_r      <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= '0;
      first_err_r  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            mode_r       <= mode;
            base_r       <= base_addr;
            nb_r         <= num_bursts;
            len_r        <= len_eff_s;
            burst_idx_r  <= '0;
            beat_r       <= '0;
            addr_r       <= base_addr;
            address_r    <= base_addr;
            burstcount_r <= len_eff_s;
            done_r       <= 1'b0;
            err_r        <= '0;
            first_err_r  <= '0;
            if (num_bursts == {CNT_W{1'b0}}) begin
              state_r <= DONE;
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
            end else if (mode == 2'd1 || mode == 2'd2) begin
              state_r <= WR_CMD;
              write_r <= 1'b1;
              wdata_r <= pattern(base_addr);
              busy_r  <= 1'b1;
            end else begin
              state_r <= RD_CMD;
              read_r  <= 1'b1;
              busy_r  <= 1'b1;
            end
          end
        end
        // WR_CMD carries beat 0; both states share the per-beat acceptance logic.
        WR_CMD, WR_DATA: begin
          if (!avm.avm_waitrequest) begin
            if (!last_beat_s) begin
              state_r <= WR_DATA;
              beat_r  <= beat_r + ONE_B;
              wdata_r <= pattern(beat_addr_s + ONE_A);
            end else if (!last_burst_s) begin
              state_r     <= WR_CMD;
              burst_idx_r <= burst_idx_r + ONE_C;
              beat_r      <= '0;
              addr_r      <= next_addr_s;
              address_r   <= next_addr_s;
              wdata_r     <= pattern(next_addr_s);
            end else if (mode_r == 2'd2) begin
              state_r     <= RD_CMD;
              write_r     <= 1'b0;
              read_r      <= 1'b1;
              burst_idx_r <= '0;
              beat_r      <= '0;
              addr_r      <= base_r;
              address_r   <= base_r;
            end else begin
              state_r <= DONE;
              write_r <= 1'b0;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end
          end
        end
        RD_CMD: begin
          if (!avm.avm_waitrequest) begin
            read_r  <= 1'b0;
            beat_r  <= '0;
            state_r <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (avm.avm_readdatavalid) begin
            if (mode_r == 2'd2 && rd_mismatch_s) begin
              if (err_r != ALL1_C) begin
                err_r <= err_r + ONE_C;
              end
              if (err_r == {CNT_W{1'b0}}) begin
                first_err_r <= beat_addr_s;
              end
            end
            if (!last_beat_s) begin
              beat_r <= beat_r + ONE_B;
            end else if (!last_burst_s) begin
              state_r     <= RD_CMD;
              burst_idx_r <= burst_idx_r + ONE_C;
              addr_r      <= next_addr_s;
              address_r   <= next_addr_s;
              read_r      <= 1'b1;
            end else begin
              state_r <= DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          read_r  <= 1'b0;
          write_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign avm.avm_address    = address_r;
  assign avm.avm_burstcount = burstcount_r;
  assign avm.avm_read       = read_r;
  assign avm.avm_write      = write_r;
  assign avm.avm_writedata  = wdata_r;
  assign avm.avm_byteenable = {(DATA_W/8){1'b1}};

  assign busy           = busy_r;
  assign done           = done_r;
  assign err_count      = err_r;
  assign first_err_addr = first_err_r;
  assign leds           = {(err_r != {CNT_W{1'b0}}), done_r, busy_r, burst_idx_r[4:0]};

endmodule

// File: tb/tb_sdram_burst_tester.sv
// Directed bench for sdram_burst_tester with an Avalon burst memory model.
module tb_sdram_burst_tester;
  localparam int DATA_W = 64, ADDR_W = 29, BURST_W = 8, CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n, start;
  logic [1:0] mode;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0] num_bursts;
  logic [BURST_W-1:0] burst_len;
  logic busy, done;
  logic [CNT_W-1:0] err_count;
  logic [ADDR_W-1:0] first_err_addr;
  logic [7:0] leds;

  sdram_burst_tester_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W)) avm ();

  sdram_burst_tester #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .base_addr(base_addr),
    .num_bursts(num_bursts), .burst_len(burst_len), .avm(avm), .busy(busy), .done(done),
    .err_count(err_count), .first_err_addr(first_err_addr), .leds(leds)
  );

  always #5 clk = ~clk;

  int total, bad;

  // Memory model state and logs
  logic [63:0] mem [logic [28:0]];
  logic [28:0] wl_addr[$];
  logic [63:0] wl_data[$];
  logic [28:0] bl_addr[$];
  logic [7:0]  bl_cnt[$];
  logic [28:0] rl_addr[$];
  logic [7:0]  rl_cnt[$];
  int rd_beats, bus_cycles, stall_viol, stalls_seen;
  int wr_rem, rd_left, stall_cnt;
  logic [28:0] wr_addr, rd_addr, corrupt_addr;
  logic stall_en, corrupt_en, prev_stalled;
  logic [28:0] p_addr;
  logic [7:0]  p_bc;
  logic p_wr, p_rd;
  logic [63:0] p_wd, rdata;

  // Avalon slave: decides waitrequest and returns read beats on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      avm.avm_waitrequest = 1'b0;
      avm.avm_readdatavalid = 1'b0;
      avm.avm_readdata = 64'h0;
      wr_rem = 0; rd_left = 0; stall_cnt = 0; prev_stalled = 1'b0;
    end else begin
      if (rd_left > 0 && !(stall_en && $urandom_range(0, 2) == 0)) begin
        rdata = mem.exists(rd_addr) ? mem[rd_addr] : 64'h0;
        if (corrupt_en && rd_addr == corrupt_addr) rdata = rdata ^ 64'h1;
        avm.avm_readdata = rdata;
        avm.avm_readdatavalid = 1'b1;
        rd_addr = rd_addr + 29'd1; rd_left--; rd_beats++;
      end else begin
        avm.avm_readdatavalid = 1'b0;
      end
      if (prev_stalled) begin
        stalls_seen++;
        if (avm.avm_address !== p_addr || avm.avm_burstcount !== p_bc || avm.avm_write !== p_wr ||
            avm.avm_read !== p_rd || (p_wr && avm.avm_writedata !== p_wd)) stall_viol++;
      end
      if (stall_cnt > 0) begin avm.avm_waitrequest = 1'b1; stall_cnt--; end
      else avm.avm_waitrequest = 1'b0;
      if (avm.avm_write || avm.avm_read) bus_cycles++;
      if (avm.avm_write && !avm.avm_waitrequest) begin
        if (wr_rem == 0) begin
          wr_addr = avm.avm_address; wr_rem = int'(avm.avm_burstcount);
          bl_addr.push_back(avm.avm_address); bl_cnt.push_back(avm.avm_burstcount);
        end
        mem[wr_addr] = avm.avm_writedata;
        wl_addr.push_back(wr_addr); wl_data.push_back(avm.avm_writedata);
        wr_addr = wr_addr + 29'd1; wr_rem--;
        stall_cnt = stall_en ? int'($urandom_range(0, 5)) : 0;
      end
      if (avm.avm_read && !avm.avm_waitrequest) begin
        rd_addr = avm.avm_address; rd_left = int'(avm.avm_burstcount);
        rl_addr.push_back(avm.avm_address); rl_cnt.push_back(avm.avm_burstcount);
        stall_cnt = stall_en ? int'($urandom_range(0, 5)) : 0;
      end
      prev_stalled = (avm.avm_write || avm.avm_read) && avm.avm_waitrequest;
      p_addr = avm.avm_address; p_bc = avm.avm_burstcount; p_wr = avm.avm_write;
      p_rd = avm.avm_read; p_wd = avm.avm_writedata;
    end
  end

  task automatic clear_logs();
    wl_addr.delete(); wl_data.delete(); bl_addr.delete(); bl_cnt.delete();
    rl_addr.delete(); rl_cnt.delete();
    rd_beats = 0; bus_cycles = 0; stall_viol = 0; stalls_seen = 0;
  endtask

  task automatic do_start(input logic [1:0] m, input logic [28:0] b, input logic [15:0] nb, input logic [7:0] l);
    @(negedge clk);
    mode = m; base_addr = b; num_bursts = nb; burst_len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (done === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if ({avm.avm_write, avm.avm_read, busy, done} !== 4'b0000) begin bad++; $display("FAIL reset_ctl: got %b want 0000", {avm.avm_write, avm.avm_read, busy, done}); end
    total++; if (avm.avm_address !== 29'h0 || avm.avm_burstcount !== 8'h0) begin bad++; $display("FAIL reset_addr: got %0h/%0h want 0/0", avm.avm_address, avm.avm_burstcount); end
    total++; if (avm.avm_writedata !== 64'h0) begin bad++; $display("FAIL reset_wdata: got %0h want 0", avm.avm_writedata); end
    total++; if (avm.avm_byteenable !== 8'hFF) begin bad++; $display("FAIL reset_be: got %0h want ff", avm.avm_byteenable); end
    total++; if (err_count !== 16'h0 || first_err_addr !== 29'h0) begin bad++; $display("FAIL reset_err: got %0h/%0h want 0/0", err_count, first_err_addr); end
    total++; if (leds !== 8'h00) begin bad++; $display("FAIL reset_leds: got %0h want 00", leds); end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_verify();
    bit ok;
    logic [31:0] w;
    clear_logs();
    do_start(2'd2, 29'h100, 16'd2, 8'd4);
    wait_done(200, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL wv_timeout: got %0d want 1", ok); end
    total++; if (wl_addr.size() !== 8) begin bad++; $display("FAIL wv_wr_beats: got %0d want 8", wl_addr.size()); end
    for (int i = 0; i < 8; i++) begin
      w = 32'hA5A50100 + 32'(i);
      total++; if (wl_addr[i] !== 29'h100 + 29'(i) || wl_data[i] !== {w, w}) begin bad++; $display("FAIL wv_beat%0d: got %0h@%0h want %0h@%0h", i, wl_data[i], wl_addr[i], {w, w}, 29'h100 + 29'(i)); end
    end
    total++; if (bl_addr[0] !== 29'h100 || bl_addr[1] !== 29'h104 || bl_cnt[0] !== 8'd4 || bl_cnt[1] !== 8'd4) begin bad++; $display("FAIL wv_wr_bursts: got %0h/%0h cnt %0d/%0d want 100/104 cnt 4/4", bl_addr[0], bl_addr[1], bl_cnt[0], bl_cnt[1]); end
    total++; if (rd_beats !== 8 || rl_addr[0] !== 29'h100 || rl_addr[1] !== 29'h104) begin bad++; $display("FAIL wv_reads: got %0d beats @%0h/%0h want 8 @100/104", rd_beats, rl_addr[0], rl_addr[1]); end
    total++; if ({done, busy} !== 2'b10 || err_count !== 16'h0) begin bad++; $display("FAIL wv_status: got done/busy %b err %0d want 10 err 0", {done, busy}, err_count); end
    total++; if (leds !== 8'h41) begin bad++; $display("FAIL wv_leds: got %0h want 41", leds); end
  endtask

  task automatic test_corrupt();
    bit ok;
    clear_logs();
    corrupt_addr = 29'h105; corrupt_en = 1'b1;
    do_start(2'd2, 29'h100, 16'd2, 8'd4);
    wait_done(200, ok);
    corrupt_en = 1'b0;
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL cor_timeout: got %0d want 1", ok); end
    total++; if (err_count !== 16'd1) begin bad++; $display("FAIL cor_err: got %0d want 1", err_count); end
    total++; if (first_err_addr !== 29'h105) begin bad++; $display("FAIL cor_first: got %0h want 105", first_err_addr); end
    total++; if (leds !== 8'hC1) begin bad++; $display("FAIL cor_leds: got %0h want c1", leds); end
  endtask

  task automatic test_stall();
    bit ok;
    logic [31:0] w;
    clear_logs();
    stall_en = 1'b1;
    do_start(2'd2, 29'h200, 16'd3, 8'd5);
    repeat (6) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL st_busy: got %b want 1", busy); end
    mode = 2'd1; base_addr = 29'h0; num_bursts = 16'd5; burst_len = 8'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(2000, ok);
    stall_en = 1'b0;
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL st_timeout: got %0d want 1", ok); end
    total++; if (wl_addr.size() !== 15) begin bad++; $display("FAIL st_wr_beats: got %0d want 15", wl_addr.size()); end
    for (int i = 0; i < 15; i++) begin
      w = 32'hA5A50200 + 32'(i);
      total++; if (wl_addr[i] !== 29'h200 + 29'(i) || wl_data[i] !== {w, w}) begin bad++; $display("FAIL st_beat%0d: got %0h@%0h want %0h@%0h", i, wl_data[i], wl_addr[i], {w, w}, 29'h200 + 29'(i)); end
    end
    total++; if (rd_beats !== 15 || err_count !== 16'h0) begin bad++; $display("FAIL st_reads: got %0d beats err %0d want 15 err 0", rd_beats, err_count); end
    total++; if (stall_viol !== 0) begin bad++; $display("FAIL st_hold: got %0d changes want 0", stall_viol); end
    total++; if (stalls_seen == 0) begin bad++; $display("FAIL st_stalls: got %0d want >0", stalls_seen); end
    total++; if (leds !== 8'h42) begin bad++; $display("FAIL st_leds: got %0h want 42", leds); end
  endtask

  task automatic test_len_edges();
    bit ok;
    clear_logs();
    do_start(2'd1, 29'h40, 16'd3, 8'd0);
    wait_done(100, ok);
    total++; if (ok !== 1'b1 || bl_cnt.size() !== 3) begin bad++; $display("FAIL len0_bursts: got ok %0d n %0d want 1 3", ok, bl_cnt.size()); end
    for (int i = 0; i < 3; i++) begin
      total++; if (bl_cnt[i] !== 8'd1 || bl_addr[i] !== 29'h40 + 29'(i)) begin bad++; $display("FAIL len0_b%0d: got %0d@%0h want 1@%0h", i, bl_cnt[i], bl_addr[i], 29'h40 + 29'(i)); end
    end
    total++; if (rl_cnt.size() !== 0) begin bad++; $display("FAIL len0_noread: got %0d want 0", rl_cnt.size()); end
    clear_logs();
    do_start(2'd0, 29'h1000, 16'd1, 8'd200);
    wait_done(400, ok);
    total++; if (ok !== 1'b1 || rl_cnt[0] !== 8'd128 || rd_beats !== 128) begin bad++; $display("FAIL clamp: got ok %0d cnt %0d beats %0d want 1 128 128", ok, rl_cnt[0], rd_beats); end
    total++; if (err_count !== 16'h0 || wl_addr.size() !== 0) begin bad++; $display("FAIL rdonly: got err %0d writes %0d want 0 0", err_count, wl_addr.size()); end
    clear_logs();
    do_start(2'd3, 29'h2000, 16'd2, 8'd2);
    wait_done(100, ok);
    total++; if (ok !== 1'b1 || rl_addr[0] !== 29'h2000 || rl_addr[1] !== 29'h2002 || rd_beats !== 4) begin bad++; $display("FAIL mode3: got ok %0d %0h/%0h beats %0d want 1 2000/2002 4", ok, rl_addr[0], rl_addr[1], rd_beats); end
    total++; if (err_count !== 16'h0 || wl_addr.size() !== 0) begin bad++; $display("FAIL mode3_nowr: got err %0d writes %0d want 0 0", err_count, wl_addr.size()); end
  endtask

  task automatic test_zero_bursts();
    clear_logs();
    do_start(2'd2, 29'h500, 16'd0, 8'd4);
    total++; if ({done, busy} !== 2'b10) begin bad++; $display("FAIL nb0_done: got done/busy %b want 10", {done, busy}); end
    repeat (3) @(negedge clk);
    #1;
    total++; if (bus_cycles !== 0 || wl_addr.size() !== 0 || rl_addr.size() !== 0) begin bad++; $display("FAIL nb0_bus: got %0d cycles want 0", bus_cycles); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL nb0_hold: got %b want 1", done); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_logs();
    do_start(2'd1, 29'h300, 16'd2, 8'd4);
    for (int i = 0; i < 50 && wl_addr.size() < 2; i++) begin @(negedge clk); #1; end
    @(posedge clk); #1;
    total++; if (avm.avm_writedata !== 64'hA5A50302_A5A50302) begin bad++; $display("FAIL rm_beat2: got %0h want a5a50302a5a50302", avm.avm_writedata); end
    rst_n = 1'b0;
    #1;
    total++; if ({avm.avm_write, avm.avm_read, busy, done} !== 4'b0000 || avm.avm_address !== 29'h0 || avm.avm_writedata !== 64'h0 || avm.avm_burstcount !== 8'h0) begin bad++; $display("FAIL rm_outs: got wr %b addr %0h data %0h want 0", avm.avm_write, avm.avm_address, avm.avm_writedata); end
    total++; if (leds !== 8'h00 || avm.avm_byteenable !== 8'hFF) begin bad++; $display("FAIL rm_leds: got %0h be %0h want 00 ff", leds, avm.avm_byteenable); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    do_start(2'd2, 29'h300, 16'd2, 8'd4);
    wait_done(200, ok);
    total++; if (ok !== 1'b1 || wl_addr.size() !== 8 || wl_addr[0] !== 29'h300 || rd_beats !== 8) begin bad++; $display("FAIL rm_rerun: got ok %0d writes %0d first %0h reads %0d want 1 8 300 8", ok, wl_addr.size(), wl_addr[0], rd_beats); end
    total++; if (err_count !== 16'h0) begin bad++; $display("FAIL rm_err: got %0d want 0", err_count); end
  endtask

  task automatic test_wrap();
    bit ok;
    clear_logs();
    do_start(2'd1, 29'h1FFFFFFE, 16'd2, 8'd4);
    wait_done(100, ok);
    total++; if (ok !== 1'b1 || bl_addr[0] !== 29'h1FFFFFFE || bl_addr[1] !== 29'h2) begin bad++; $display("FAIL wrap_addr: got ok %0d %0h/%0h want 1 1ffffffe/2", ok, bl_addr[0], bl_addr[1]); end
    total++; if (wl_addr[2] !== 29'h0 || wl_data[2] !== 64'hA5A50000_A5A50000) begin bad++; $display("FAIL wrap_beat: got %0h@%0h want a5a50000a5a50000@0", wl_data[2], wl_addr[2]); end
    total++; if (wl_data[0] !== 64'hC5A4FFFE_C5A4FFFE) begin bad++; $display("FAIL wrap_data0: got %0h want c5a4fffec5a4fffe", wl_data[0]); end
    total++; if (wl_data[7] !== 64'hA5A50005_A5A50005) begin bad++; $display("FAIL wrap_data7: got %0h want a5a50005a5a50005", wl_data[7]); end
  endtask

  initial begin
    total = 0; bad = 0;
    stall_en = 1'b0; corrupt_en = 1'b0; corrupt_addr = 29'h0;
    start = 1'b0; mode = 2'd0; base_addr = 29'h0; num_bursts = 16'd0; burst_len = 8'd0;
    rst_n = 1'b0;
    avm.avm_waitrequest = 1'b0; avm.avm_readdatavalid = 1'b0; avm.avm_readdata = 64'h0;
    rd_beats = 0; bus_cycles = 0; stall_viol = 0; stalls_seen = 0;
    wr_rem = 0; rd_left = 0; stall_cnt = 0; prev_stalled = 1'b0;
    test_reset();
    test_write_verify();
    test_corrupt();
    test_stall();
    test_len_edges();
    test_zero_bursts();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sdram_burst_tester.md
SDRAM_BURST_TESTER -- requirements
Module: sdram_burst_tester

Interface
REQ-001 Parameter DATA_W, default 64: Avalon data width in bits; SHALL be a multiple of 32.
REQ-002 Parameter ADDR_W, default 29: word-address width.
REQ-003 Parameter BURST_W, default 8: burstcount width; maximum burst length is 2^(BURST_W-1).
REQ-004 Parameter CNT_W, default 16: width of the burst counter and the error counter.
REQ-005 Parameter SEED, default 32'hA5A5_0000: 32-bit pattern seed.
REQ-006 Ports, one per line (name, direction, width, meaning); one clock, reset is asynchronous and active-low:
- clk  in  1  sole clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that begins a run
- mode  in  2  0 = read-only, 1 = write-only, 2 = write-then-verify, 3 = reserved (treated as 0)
- base_addr  in  ADDR_W  first word address
- num_bursts  in  CNT_W  number of bursts per phase
- burst_len  in  BURST_W  beats per burst
- avm_address  out  ADDR_W  Avalon address
- avm_burstcount  out  BURST_W  Avalon burstcount
- avm_read  out  1  Avalon read
- avm_write  out  1  Avalon write
- avm_writedata  out  DATA_W  Avalon write data
- avm_byteenable  out  DATA_W/8  always all ones
- avm_waitrequest  in  1  Avalon waitrequest
- avm_readdata  in  DATA_W  Avalon read data
- avm_readdatavalid  in  1  Avalon readdatavalid
- busy  out  1  run in progress
- done  out  1  high from run completion until the next accepted start
- err_count  out  CNT_W  number of mismatching read beats, saturating
- first_err_addr  out  ADDR_W  word address of the first mismatch
- leds  out  8  status display

Function
REQ-007 start, mode, base_addr, num_bursts and burst_len SHALL be sampled only in IDLE when start=1; start SHALL be ignored in every other state.
REQ-008 burst_len=0 SHALL be treated as 1; values above 2^(BURST_W-1) SHALL be clamped to that maximum.
REQ-009 num_bursts=0 SHALL go IDLE -> DONE in one cycle, with no bus activity.
REQ-010 FSM states SHALL be IDLE, WR_CMD, WR_DATA, RD_CMD, RD_DATA, DONE.
REQ-011 IDLE SHALL transition on start to WR_CMD for modes 1 and 2, and to RD_CMD for modes 0 and 3.
REQ-012 Burst k (0-based) SHALL use avm_address = base_addr + k*L, computed modulo 2^ADDR_W, where L is the effective burst length.
REQ-013 Pattern word for absolute word address A SHALL be (A[31:0] + SEED) replicated DATA_W/32 times; address bits above 31 SHALL be ignored.
REQ-014 WR_CMD SHALL assert avm_write with the burst address, burstcount=L and beat 0 data.
REQ-015 A write beat SHALL be accepted on the cycle avm_write=1 and avm_waitrequest=0.
REQ-016 All write outputs SHALL hold while waitrequest=1.
REQ-017 Beats 1..L-1 SHALL be driven in WR_DATA with avm_write held high.
REQ-018 After the last beat of the last burst the FSM SHALL enter RD_CMD (mode 2) or DONE (mode 1).
REQ-019 RD_CMD SHALL assert avm_read for exactly one accepted cycle (avm_read=1, avm_waitrequest=0), then enter RD_DATA.
REQ-020 In RD_DATA the block SHALL count L readdatavalid beats, then issue the next burst or, after the last burst, enter DONE; at most one read burst SHALL be outstanding.
REQ-021 In mode 2 each valid beat SHALL be compared with the pattern for its address.
REQ-022 On a mismatch err_count SHALL increment and saturate at all ones; first_err_addr SHALL be captured only when err_count was 0.
REQ-023 Modes 0 and 3 SHALL perform no comparison.
REQ-024 readdatavalid outside RD_DATA SHALL be ignored.
REQ-025 DONE SHALL hold done=1 and busy=0 and return to IDLE in the next cycle; done SHALL remain high until the next accepted start.
REQ-026 An accepted start SHALL clear done, err_count and first_err_addr in the same edge.
REQ-027 busy SHALL be 1 in every state except IDLE and DONE.
REQ-028 leds SHALL equal {err_count!=0, done, busy, burst_index[4:0]}, where burst_index is the current k.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, all outputs to 0 except avm_byteenable (all ones), and all counters to 0.
REQ-030 Reset mid-burst SHALL abandon the transaction without completing it.
REQ-031 The block SHALL leave reset only on a clk edge with rst_n high.

Verification
REQ-032 Mode 2, base=0x100, num_bursts=2, L=4, no waitrequest, ideal memory -> 8 write beats with data 0xA5A50100.. replicated; 8 read beats; done=1; err_count=0.
REQ-033 Same run, memory corrupts the word at 0x105 -> err_count=1; first_err_addr=0x105; leds[7]=1.
REQ-034 Random waitrequest stalls of 0-5 cycles -> address, burstcount and writedata stable while stalled; no beat lost or duplicated.
REQ-035 burst_len=0 with num_bursts=3 -> three bursts with burstcount=1; num_bursts=0 -> done the cycle after start with no bus activity.
REQ-036 rst_n pulsed low during WR_DATA beat 2 -> all outputs 0 asynchronously; a fresh start afterwards completes normally.
REQ-037 base=2^ADDR_W-2 with L=4 -> second burst address wraps to 2.
